// File: rtl/mtimer_pkg.sv
// ============================================================================
// Module : mtimer_pkg
// Brief  : Register offsets, CTRL bit positions and reset constants for mtimer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mtimer_pkg;

    localparam logic [31:0] MTIME_LO    = 32'h00;
    localparam logic [31:0] MTIME_HI    = 32'h04;
    localparam logic [31:0] MTIMECMP_LO = 32'h08;
    localparam logic [31:0] MTIMECMP_HI = 32'h0C;
    localparam logic [31:0] CTRL        = 32'h10;

    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mtimer_prescaler.sv
// ============================================================================
// Module : mtimer_prescaler
// Brief  : Divides i_clk by CLK_DIV into a one-cycle tick while enabled.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mtimer_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en & (r_cnt == c_last);

    // Counter sits at zero whenever disabled so re-enabling starts a full period.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mtimer.sv
// ============================================================================
// Module : mtimer
// Brief  : Machine timer with 64-bit mtime/mtimecmp behind a req/ack bus port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mtimer
    import mtimer_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ack,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic              o_t_irq
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_cnt_en;
    logic        r_irq_en;
    logic [31:0] r_hi_shadow;
    logic        r_snap_valid;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic [31:0] w_off;
    logic        w_err;
    logic        w_ok;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_mlo;
    logic        w_wr_mhi;
    logic        w_wr_ctrl;
    logic        w_tick;
    logic [31:0] w_rd_val;

    assign w_off     = 32'(i_addr);
    assign w_err     = (i_addr[1:0] != 2'b00) || (w_off > CTRL);
    assign w_ok      = i_req & ~w_err;
    assign w_wr      = w_ok & i_we;
    assign w_rd      = w_ok & ~i_we;
    assign w_wr_mlo  = w_wr & (w_off == MTIME_LO);
    assign w_wr_mhi  = w_wr & (w_off == MTIME_HI);
    assign w_wr_ctrl = w_wr & (w_off == CTRL);

    mtimer_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_cnt_en),
        .i_clr   (w_wr_ctrl & ~i_wdata[CTRL_CNT_EN]),
        .o_tick  (w_tick)
    );

    // A MTIME_HI read directly after a MTIME_LO read returns the half captured with LO.
    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            MTIME_LO:    w_rd_val = r_mtime[31:0];
            MTIME_HI:    w_rd_val = r_snap_valid ? r_hi_shadow : r_mtime[63:32];
            MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
            CTRL:        w_rd_val = {30'd0, r_irq_en, r_cnt_en};
            default:     w_rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtime      <= 64'd0;
            r_mtimecmp   <= MTIMECMP_RST;
            r_cnt_en     <= 1'b1;
            r_irq_en     <= 1'b1;
            r_hi_shadow  <= 32'd0;
            r_snap_valid <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
            r_irq        <= 1'b0;
        end else begin
            // A software write to either mtime half wins over the tick that cycle.
            if (w_tick && !w_wr_mlo && !w_wr_mhi) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr_mlo) r_mtime[31:0]  <= i_wdata;
            if (w_wr_mhi) r_mtime[63:32] <= i_wdata;
            if (w_wr && (w_off == MTIMECMP_LO)) r_mtimecmp[31:0]  <= i_wdata;
            if (w_wr && (w_off == MTIMECMP_HI)) r_mtimecmp[63:32] <= i_wdata;
            if (w_wr_ctrl) begin
                r_cnt_en <= i_wdata[CTRL_CNT_EN];
                r_irq_en <= i_wdata[CTRL_IRQ_EN];
            end

            if (w_ok) begin
                if (w_rd && (w_off == MTIME_LO)) begin
                    r_hi_shadow  <= r_mtime[63:32];
                    r_snap_valid <= 1'b1;
                end else begin
                    r_snap_valid <= 1'b0;
                end
            end

            r_ack   <= i_req;
            r_err   <= i_req & w_err;
            r_rdata <= w_rd ? w_rd_val : 32'd0;
            r_irq   <= r_irq_en & (r_mtime >= r_mtimecmp);
        end
    end

    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;
    assign o_t_irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mtimer.sv
// ============================================================================
// Module : tb_mtimer
// Brief  : Self-checking bench for mtimer (CLK_DIV=1 and CLK_DIV=4 side by side).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mtimer;

    localparam logic [4:0] A_LO   = 5'h00;
    localparam logic [4:0] A_HI   = 5'h04;
    localparam logic [4:0] A_CLO  = 5'h08;
    localparam logic [4:0] A_CHI  = 5'h0C;
    localparam logic [4:0] A_CTRL = 5'h10;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [4:0]  i_addr;
    logic [31:0] i_wdata;
    logic        o_ack,  o_err,  o_t_irq;
    logic [31:0] o_rdata;
    logic        o_ack4, o_err4, o_t_irq4;
    logic [31:0] o_rdata4;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mtimer #(.CLK_DIV(1), .ADDR_W(5)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack), .o_err(o_err),
        .o_rdata(o_rdata), .o_t_irq(o_t_irq)
    );

    mtimer #(.CLK_DIV(4), .ADDR_W(5)) u_dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack4), .o_err(o_err4),
        .o_rdata(o_rdata4), .o_t_irq(o_t_irq4)
    );

    typedef struct {
        logic [63:0] mtime;
        logic [63:0] cmp;
        logic        cnt_en;
        logic        irq_en;
        int          pc;
        logic [31:0] shadow;
        logic        snap;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        irq;
    } mstate_t;

    function automatic mstate_t reset_state();
        mstate_t r;
        r.mtime = 64'd0;  r.cmp = '1;     r.cnt_en = 1'b1; r.irq_en = 1'b1;
        r.pc = 0;         r.shadow = '0;  r.snap = 1'b0;   r.ack = 1'b0;
        r.err = 1'b0;     r.rdata = '0;   r.irq = 1'b0;
        return r;
    endfunction

    // One clock of the timer as seen from the bus: state after the edge given the inputs before it.
    function automatic mstate_t step(mstate_t s, int div, logic rst_n, logic req, logic we,
                                     logic [4:0] a, logic [31:0] wd);
        mstate_t n;
        logic    tick, bad, mt_wr;
        if (!rst_n) return reset_state();
        n     = s;
        tick  = s.cnt_en && (s.pc == div - 1);
        n.pc  = (!s.cnt_en || tick) ? 0 : s.pc + 1;
        bad   = (a[1:0] != 2'b00) || (a > A_CTRL);
        n.ack = req;
        n.err = req && bad;
        n.rdata = '0;
        n.irq = s.irq_en && (s.mtime >= s.cmp);
        mt_wr = 1'b0;
        if (req && !bad) begin
            if (we) begin
                case (a)
                    A_LO:   begin n.mtime[31:0]  = wd; mt_wr = 1'b1; end
                    A_HI:   begin n.mtime[63:32] = wd; mt_wr = 1'b1; end
                    A_CLO:  n.cmp[31:0]  = wd;
                    A_CHI:  n.cmp[63:32] = wd;
                    default: begin
                        n.cnt_en = wd[0];
                        n.irq_en = wd[1];
                        if (!wd[0]) n.pc = 0;
                    end
                endcase
            end else begin
                case (a)
                    A_LO:    n.rdata = s.mtime[31:0];
                    A_HI:    n.rdata = s.snap ? s.shadow : s.mtime[63:32];
                    A_CLO:   n.rdata = s.cmp[31:0];
                    A_CHI:   n.rdata = s.cmp[63:32];
                    default: n.rdata = {30'd0, s.irq_en, s.cnt_en};
                endcase
            end
            n.snap = !we && (a == A_LO);
            if (n.snap) n.shadow = s.mtime[63:32];
        end
        if (tick && !mt_wr) n.mtime = s.mtime + 64'd1;
        return n;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    mstate_t m1, m4;
    bit      started = 1'b0;

    always @(posedge i_clk) begin
        m1 = step(m1, 1, i_rst_n, i_req, i_we, i_addr, i_wdata);
        m4 = step(m4, 4, i_rst_n, i_req, i_we, i_addr, i_wdata);
        if (!i_rst_n) started = 1'b1;
    end

    always @(negedge i_clk) begin
        if (started) begin
            check("ack_div1", o_ack,   m1.ack);
            check("err_div1", o_err,   m1.err);
            check("irq_div1", o_t_irq, m1.irq);
            if (m1.ack) check("rdata_div1", o_rdata, m1.rdata);
            check("ack_div4", o_ack4,   m4.ack);
            check("err_div4", o_err4,   m4.err);
            check("irq_div4", o_t_irq4, m4.irq);
            if (m4.ack) check("rdata_div4", o_rdata4, m4.rdata);
        end
    end

    task automatic cyc(input logic req, input logic we, input logic [4:0] a, input logic [31:0] d);
        i_req = req; i_we = we; i_addr = a; i_wdata = d;
        @(posedge i_clk);
        #1;
        i_req = 1'b0; i_we = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'h00, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d1, output logic [31:0] d4);
        cyc(1'b1, 1'b0, a, 32'd0);
        d1 = o_rdata;
        d4 = o_rdata4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, d4;
        int          n;
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ack",   o_ack,   0);
        check("rst_err",   o_err,   0);
        check("rst_rdata", o_rdata, 0);
        check("rst_irq",   o_t_irq, 0);
        i_rst_n = 1'b1;

        // T1: free-running count straight out of reset
        rd(A_LO, d1, d4); check("t1_lo0", d1, 0); check("t1_div4_lo0", d4, 0);
        rd(A_LO, d1, d4); check("t1_lo1", d1, 1); check("t1_div4_lo1", d4, 0);
        rd(A_LO, d1, d4); check("t1_lo2", d1, 2); check("t1_div4_lo2", d4, 0);
        check("t1_irq", o_t_irq, 0);
        rd(A_CTRL, d1, d4); check("t1_ctrl", d1, 32'h3);

        // T2: compare match raises irq, raising mtimecmp drops it
        wr(A_CHI, 32'd0);
        wr(A_CLO, 32'd20);
        n = 0;
        while (!o_t_irq && n < 40) begin idle(); n++; end
        check("t2_irq_timeout", (n < 40), 1);
        rd(A_LO, d1, d4); check("t2_lo_at_irq", d1, 21);
        wr(A_CLO, 32'hFFFF_FFFF);
        check("t2_irq_hold", o_t_irq, 1);
        idle();
        check("t2_irq_fall", o_t_irq, 0);

        // T3: carry into HI, then full 64-bit wrap
        wr(A_HI, 32'd0);
        wr(A_LO, 32'hFFFF_FFFE);
        idle(); idle();
        rd(A_LO, d1, d4); check("t3_carry_lo", d1, 0);
        rd(A_HI, d1, d4); check("t3_carry_hi", d1, 1);
        wr(A_HI, 32'hFFFF_FFFF);
        wr(A_LO, 32'hFFFF_FFFF);
        idle();
        rd(A_LO, d1, d4); check("t3_wrap_lo", d1, 0);
        rd(A_HI, d1, d4); check("t3_wrap_hi", d1, 0);

        // T4: HI read after LO returns the snapshot taken before the carry
        wr(A_HI, 32'd0);
        wr(A_LO, 32'hFFFF_FFFE);
        idle();
        rd(A_LO, d1, d4); check("t4_lo", d1, 32'hFFFF_FFFF);
        rd(A_HI, d1, d4); check("t4_hi_shadow", d1, 0);

        // T5: write in a tick cycle suppresses the increment
        wr(A_LO, 32'd100);
        rd(A_LO, d1, d4); check("t5_lo100", d1, 100);
        rd(A_LO, d1, d4); check("t5_lo101", d1, 101);

        // T5: divide-by-4 cadence and freeze
        wr(A_CTRL, 32'h2);
        wr(A_HI, 32'd0);
        wr(A_LO, 32'd0);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 9; i++) begin
            rd(A_LO, d1, d4);
            check("t5_div1_run", d1, i);
            check("t5_div4_run", d4, i / 4);
        end
        wr(A_CTRL, 32'h2);
        rd(A_LO, d1, d4); check("t5_frz_a", d1, 10); check("t5_frz4_a", d4, 2);
        rd(A_LO, d1, d4); check("t5_frz_b", d1, 10); check("t5_frz4_b", d4, 2);

        // T6: error accesses
        rd(5'h02, d1, d4);
        check("t6_e02_ack", o_ack, 1); check("t6_e02_err", o_err, 1); check("t6_e02_rd", d1, 0);
        rd(5'h14, d1, d4);
        check("t6_e14_ack", o_ack, 1); check("t6_e14_err", o_err, 1); check("t6_e14_rd", d1, 0);
        wr(5'h14, 32'hFFFF_FFFF);
        rd(A_CTRL, d1, d4); check("t6_ctrl_kept", d1, 32'h2);
        rd(A_LO, d1, d4); check("t6_lo_kept", d1, 10); check("t6_lo4_kept", d4, 2);

        // T6: reset in the middle of an access
        wr(A_CLO, 32'd5);
        idle();
        check("t6_irq_pre", o_t_irq, 1);
        i_rst_n = 1'b0;
        cyc(1'b1, 1'b0, A_LO, 32'd0);
        check("t6_rst_ack",   o_ack,   0);
        check("t6_rst_err",   o_err,   0);
        check("t6_rst_rdata", o_rdata, 0);
        check("t6_rst_irq",   o_t_irq, 0);
        i_rst_n = 1'b1;
        rd(A_LO,  d1, d4); check("t6_post_lo",   d1, 0);
        rd(A_CHI, d1, d4); check("t6_post_cmp",  d1, 32'hFFFF_FFFF);
        rd(A_CTRL, d1, d4); check("t6_post_ctrl", d1, 32'h3);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
